// File: rtl/mips_cpu_avalon.sv
// Multi-cycle MIPS32 integer subset CPU with one shared Avalon-MM master bus.
// Each instruction runs FETCH -> EXEC -> (MEM for LW/SW). Branches and jumps
// have one delay slot. The core halts when the PC would become zero.
module mips_cpu_avalon #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             br_pend_q, br_pend_d;
    logic [31:0][31:0] gpr_q, gpr_d;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] idx;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign idx    = ir_q[25:0];

    logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4, mem_addr, npc;
    logic        is_lw, is_sw;
    assign rs_val   = gpr_q[rs];
    assign rt_val   = gpr_q[rt];
    assign imm_s    = {{16{imm[15]}}, imm};
    assign imm_z    = {16'h0, imm};
    assign pc_plus4 = pc_q + 32'd4;
    // Register values are untouched between EXEC and MEM, so this stays stable
    // for the whole memory access, including waitrequest stalls.
    assign mem_addr = (rs_val + imm_s) & 32'hFFFF_FFFC;
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    // A pending branch target takes effect after the delay-slot instruction.
    assign npc      = br_pend_q ? tgt_q : pc_plus4;

    assign active      = active_q;
    assign register_v0 = gpr_q[2];

    // Execute: ALU result, writeback destination and branch/jump decision
    logic        ex_wen, ex_jump;
    logic [4:0]  ex_dst;
    logic [31:0] ex_val, ex_tgt;
    always_comb begin
        ex_wen  = 1'b0;
        ex_dst  = rt;
        ex_val  = 32'h0;
        ex_jump = 1'b0;
        ex_tgt  = 32'h0;
        case (opcode)
            6'h00: begin
                ex_dst = rd;
                ex_wen = 1'b1;
                case (funct)
                    6'h21: ex_val = rs_val + rt_val;
                    6'h23: ex_val = rs_val - rt_val;
                    6'h24: ex_val = rs_val & rt_val;
                    6'h25: ex_val = rs_val | rt_val;
                    6'h26: ex_val = rs_val ^ rt_val;
                    6'h2A: ex_val = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: ex_val = {31'h0, rs_val < rt_val};
                    6'h00: ex_val = rt_val << shamt;
                    6'h02: ex_val = rt_val >> shamt;
                    6'h03: ex_val = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        ex_wen  = 1'b0;
                        ex_jump = 1'b1;
                        ex_tgt  = rs_val;
                    end
                    default: ex_wen = 1'b0;
                endcase
            end
            6'h02: begin
                ex_jump = 1'b1;
                ex_tgt  = {pc_plus4[31:28], idx, 2'b00};
            end
            6'h03: begin
                ex_jump = 1'b1;
                ex_tgt  = {pc_plus4[31:28], idx, 2'b00};
                ex_wen  = 1'b1;
                ex_dst  = 5'd31;
                ex_val  = pc_q + 32'd8;
            end
            6'h04: begin
                ex_jump = (rs_val == rt_val);
                ex_tgt  = pc_plus4 + (imm_s << 2);
            end
            6'h05: begin
                ex_jump = (rs_val != rt_val);
                ex_tgt  = pc_plus4 + (imm_s << 2);
            end
            6'h09: begin ex_wen = 1'b1; ex_val = rs_val + imm_s; end
            6'h0A: begin ex_wen = 1'b1; ex_val = {31'h0, $signed(rs_val) < $signed(imm_s)}; end
            6'h0B: begin ex_wen = 1'b1; ex_val = {31'h0, rs_val < imm_s}; end
            6'h0C: begin ex_wen = 1'b1; ex_val = rs_val & imm_z; end
            6'h0D: begin ex_wen = 1'b1; ex_val = rs_val | imm_z; end
            6'h0E: begin ex_wen = 1'b1; ex_val = rs_val ^ imm_z; end
            6'h0F: begin ex_wen = 1'b1; ex_val = {imm, 16'h0}; end
            default: ;
        endcase
    end

    // Bus outputs: driven purely from registered state, so they hold under waitrequest
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    read       = 1'b1;
                    address    = pc_q;
                    byteenable = 4'hF;
                end
                S_MEM: begin
                    address    = mem_addr;
                    byteenable = 4'hF;
                    if (is_lw) begin
                        read = 1'b1;
                    end else begin
                        write     = 1'b1;
                        writedata = rt_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state: sequencing, PC/delay-slot tracking and register writeback
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        tgt_d     = tgt_q;
        br_pend_d = br_pend_q;
        gpr_d     = gpr_q;
        case (state_q)
            S_FETCH: begin
                if (!active_q) begin
                    active_d = 1'b1;
                end else if (!waitrequest) begin
                    ir_d    = readdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d      = npc;
                br_pend_d = ex_jump;
                tgt_d     = ex_tgt;
                if (ex_wen && ex_dst != 5'd0) gpr_d[ex_dst] = ex_val;
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (npc == 32'h0) begin
                    state_d  = S_HALT;
                    active_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (!waitrequest) begin
                    if (is_lw && rt != 5'd0) gpr_d[rt] = readdata;
                    if (pc_q == 32'h0) begin
                        state_d  = S_HALT;
                        active_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            active_q  <= 1'b0;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 32'h0;
            tgt_q     <= 32'h0;
            br_pend_q <= 1'b0;
            gpr_q     <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            tgt_q     <= tgt_d;
            br_pend_q <= br_pend_d;
            gpr_q     <= gpr_d;
        end
    end
endmodule

// File: tb/tb_mips_cpu_avalon.sv
// Bench for mips_cpu_avalon: program and expected bus trace are tables; a
// bus slave model answers requests, inserts stalls and checks each accepted
// transaction against the scoreboard queue.
module tb_mips_cpu_avalon;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'h0;
    logic        active, write, read;
    logic [31:0] register_v0, address, writedata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_avalon dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    typedef struct {
        logic [31:0] off;
        logic [31:0] instr;
    } prog_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] v0;
    } txn_t;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    prog_t       prog[40];
    int          n_prog = 0;
    txn_t        trace[40];
    int          n_trace = 0;
    txn_t        exp_q[$];
    logic [31:0] imem[64];
    logic [31:0] dmem[16];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          sb_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic p(input logic [31:0] off, input logic [31:0] instr);
        prog[n_prog] = '{off: off, instr: instr};
        n_prog++;
    endtask

    task automatic t(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] v0);
        trace[n_trace] = '{wr: wr, addr: addr, wdata: wd, v0: v0};
        n_trace++;
    endtask

    function automatic int stall_for(input int i);
        case (i)
            0: return 3;
            1: return 2;
            4: return 2;
            9: return 1;
            default: return 0;
        endcase
    endfunction

    // Bus slave + scoreboard monitor, working on the falling edge
    int          txn_idx = 0;
    int          stall_left = 0;
    bit          in_txn = 1'b0;
    logic [31:0] h_addr, h_wd;
    logic        h_rd, h_wr;
    txn_t        e;
    always @(negedge clk) begin
        if (reset && (read || write)) begin
            chk("rw_exclusive", {31'h0, read & write}, 32'h0);
            if (!in_txn) begin
                in_txn     = 1'b1;
                stall_left = stall_for(txn_idx);
                h_addr = address; h_wd = writedata; h_rd = read; h_wr = write;
            end else begin
                chk("hold_addr", address, h_addr);
                chk("hold_rw", {30'h0, read, write}, {30'h0, h_rd, h_wr});
                chk("hold_wdata", writedata, h_wd);
            end
            if (stall_left > 0) begin
                waitrequest = 1'b1;
                stall_left--;
            end else begin
                waitrequest = 1'b0;
                readdata = (address[31:28] == 4'hB) ? imem[address[7:2]] : dmem[address[5:2]];
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_txn: bus access at %08h, expected none", address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_addr", address, e.addr);
                        chk("txn_write", {31'h0, write}, {31'h0, e.wr});
                        chk("txn_read", {31'h0, read}, {31'h0, ~e.wr});
                        chk("txn_be", {28'h0, byteenable}, 32'hF);
                        chk("txn_v0", register_v0, e.v0);
                        if (e.wr) chk("txn_wdata", writedata, e.wdata);
                    end
                end
                if (write) dmem[address[5:2]] = writedata;
                txn_idx++;
                in_txn = 1'b0;
            end
        end else begin
            waitrequest = 1'b0;
            in_txn = 1'b0;
        end
    end

    initial begin
        // Program, in memory order (offsets from the reset vector)
        p(32'h00, 32'h8C62_0000); // LW    $2,0($3)
        p(32'h04, 32'h2442_0005); // ADDIU $2,$2,5
        p(32'h08, 32'hAC02_0004); // SW    $2,4($0)
        p(32'h0C, 32'h2402_FFFF); // ADDIU $2,$0,-1
        p(32'h10, 32'h3C04_8000); // LUI   $4,0x8000
        p(32'h14, 32'h3405_0003); // ORI   $5,$0,3
        p(32'h18, 32'h0085_102A); // SLT   $2,$4,$5
        p(32'h1C, 32'h0085_102B); // SLTU  $2,$4,$5
        p(32'h20, 32'h0004_1103); // SRA   $2,$4,4
        p(32'h24, 32'h0004_1102); // SRL   $2,$4,4
        p(32'h28, 32'h0005_1080); // SLL   $2,$5,2
        p(32'h2C, 32'h0005_1023); // SUBU  $2,$0,$5
        p(32'h30, 32'h0084_1021); // ADDU  $2,$4,$4
        p(32'h34, 32'h3882_FFFF); // XORI  $2,$4,0xFFFF
        p(32'h38, 32'h3042_8001); // ANDI  $2,$2,0x8001
        p(32'h3C, 32'h0045_1024); // AND   $2,$2,$5
        p(32'h40, 32'h0045_1026); // XOR   $2,$2,$5
        p(32'h44, 32'h0045_1025); // OR    $2,$2,$5
        p(32'h48, 32'h2C82_FFFF); // SLTIU $2,$4,-1
        p(32'h4C, 32'h28A2_FFFF); // SLTI  $2,$5,-1
        p(32'h50, 32'h10A5_0002); // BEQ   $5,$5,+2 (taken)
        p(32'h54, 32'h2402_0007); // ADDIU $2,$0,7 (delay slot)
        p(32'h58, 32'h2402_0055); // skipped
        p(32'h5C, 32'h14A5_0005); // BNE   $5,$5,+5 (not taken)
        p(32'h60, 32'h2442_0001); // ADDIU $2,$2,1
        p(32'h64, 32'h0FF0_001C); // JAL   BFC00070
        p(32'h68, 32'h2402_0021); // ADDIU $2,$0,0x21 (delay slot)
        p(32'h6C, 32'h2402_0099); // skipped
        p(32'h70, 32'h03E0_1021); // ADDU  $2,$31,$0
        p(32'h74, 32'h0BF0_0020); // J     BFC00080
        p(32'h78, 32'hFC00_0000); // unknown opcode in delay slot
        p(32'h7C, 32'h2402_0077); // skipped
        p(32'h80, 32'h0000_0008); // JR    $0
        p(32'h84, 32'h0000_0000); // NOP (delay slot), then halt

        // Expected bus trace in execution order; v0 is the value seen at access time
        t(0, BASE + 32'h00, 0, 32'h0);
        t(0, 32'h0,         0, 32'h0);          // LW data read
        t(0, BASE + 32'h04, 0, 32'h9);
        t(0, BASE + 32'h08, 0, 32'hE);
        t(1, 32'h4,  32'hE,    32'hE);          // SW data write
        t(0, BASE + 32'h0C, 0, 32'hE);
        t(0, BASE + 32'h10, 0, 32'hFFFF_FFFF);
        t(0, BASE + 32'h14, 0, 32'hFFFF_FFFF);
        t(0, BASE + 32'h18, 0, 32'hFFFF_FFFF);
        t(0, BASE + 32'h1C, 0, 32'h1);
        t(0, BASE + 32'h20, 0, 32'h0);
        t(0, BASE + 32'h24, 0, 32'hF800_0000);
        t(0, BASE + 32'h28, 0, 32'h0800_0000);
        t(0, BASE + 32'h2C, 0, 32'hC);
        t(0, BASE + 32'h30, 0, 32'hFFFF_FFFD);
        t(0, BASE + 32'h34, 0, 32'h0);
        t(0, BASE + 32'h38, 0, 32'h8000_FFFF);
        t(0, BASE + 32'h3C, 0, 32'h8001);
        t(0, BASE + 32'h40, 0, 32'h1);
        t(0, BASE + 32'h44, 0, 32'h2);
        t(0, BASE + 32'h48, 0, 32'h3);
        t(0, BASE + 32'h4C, 0, 32'h1);
        t(0, BASE + 32'h50, 0, 32'h0);
        t(0, BASE + 32'h54, 0, 32'h0);
        t(0, BASE + 32'h5C, 0, 32'h7);
        t(0, BASE + 32'h60, 0, 32'h7);
        t(0, BASE + 32'h64, 0, 32'h8);
        t(0, BASE + 32'h68, 0, 32'h8);
        t(0, BASE + 32'h70, 0, 32'h21);
        t(0, BASE + 32'h74, 0, 32'hBFC0_006C);
        t(0, BASE + 32'h78, 0, 32'hBFC0_006C);
        t(0, BASE + 32'h80, 0, 32'hBFC0_006C);
        t(0, BASE + 32'h84, 0, 32'hBFC0_006C);

        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        dmem[0] = 32'd9;
        for (int i = 0; i < n_prog; i++) imem[prog[i].off[7:2]] = prog[i].instr;
        for (int i = 0; i < n_trace; i++) exp_q.push_back(trace[i]);

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_active", {31'h0, active}, 32'h0);
        chk("rst_read", {31'h0, read}, 32'h0);
        chk("rst_write", {31'h0, write}, 32'h0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_v0", register_v0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_active", {31'h0, active}, 32'h1);
        chk("rel_read", {31'h0, read}, 32'h1);
        chk("rel_write", {31'h0, write}, 32'h0);
        chk("rel_addr", address, BASE);

        // Run the program until the core halts
        for (int c = 0; c < 3000 && active; c++) @(negedge clk);
        chk("halt_active", {31'h0, active}, 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("halt_bus", {30'h0, read, write}, 32'h0);
        end
        chk("trace_left", exp_q.size(), 32'h0);
        chk("final_v0", register_v0, 32'hBFC0_006C);
        chk("dmem_store", dmem[1], 32'hE);

        // Reset after halt clears GPRs; reset during an instruction aborts it
        sb_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_active", {31'h0, active}, 32'h0);
        chk("rst2_v0", register_v0, 32'h0);
        chk("rst2_addr", address, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel2_read", {31'h0, read}, 32'h1);
        chk("rel2_addr", address, BASE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_active", {31'h0, active}, 32'h0);
        chk("abort_read", {31'h0, read}, 32'h0);
        chk("abort_v0", register_v0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
